// File: rtl/stream_mem_writer_pkg.sv
// Shared definitions for the stream-to-memory burst writer: controller
// state encoding and the word geometry used for address stepping.
package stream_mem_writer_pkg;

  // Burst controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Each stream word occupies four bytes of the external address space
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/stream_mem_writer.sv
// Stream-to-memory burst writer. A start request latches a word-aligned
// base address and a word count; stream words are then accepted one at a
// time and presented on a simple valid/ready write bus at consecutive word
// addresses. A one-cycle done pulse marks the end of the burst.
module stream_mem_writer
  import stream_mem_writer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    len,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  output logic                busy,
  output logic                done
);

  // Clears the sub-word bits of the requested base address
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(WORD_BYTES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                in_ready_s;
  logic                accept_s;
  logic                ack_s;
  logic                start_burst_s;

  // A new word may enter only while words remain and the holding register
  // is empty or being drained this cycle.
  assign in_ready_s = (state_q == ST_RUN) && (acc_cnt_q < len_q) &&
                      (!m_valid_q || m_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign ack_s      = m_valid_q && m_ready;

  // Controller next state, burst parameter latching and status flags
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    start_burst_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (len != {LEN_W{1'b0}}) begin
            base_d        = base_addr & ADDR_MASK;
            len_d         = len;
            start_burst_s = 1'b1;
            state_d       = ST_RUN;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ack_s && ((wr_cnt_q + LEN_W'(1'b1)) == len_q)) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word counters and the bus holding register
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    if (start_burst_s) begin
      acc_cnt_d = {LEN_W{1'b0}};
      wr_cnt_d  = {LEN_W{1'b0}};
    end else begin
      if (ack_s) begin
        wr_cnt_d = wr_cnt_q + LEN_W'(1'b1);
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (accept_s) begin
        m_valid_d = 1'b1;
        m_wdata_d = in_data;
        m_addr_d  = base_q + (ADDR_W'(acc_cnt_q) << WORD_SHIFT);
        m_wstrb_d = {(DATA_W/8){1'b1}};
        acc_cnt_d = acc_cnt_q + LEN_W'(1'b1);
      end else if (ack_s) begin
        m_valid_d = 1'b0;
      end else begin
        m_valid_d = m_valid_q;
      end
    end
  end

  // State, latched burst parameters, counters and bus output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      base_q    <= {ADDR_W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      acc_cnt_q <= {LEN_W{1'b0}};
      wr_cnt_q  <= {LEN_W{1'b0}};
      m_valid_q <= 1'b0;
      m_addr_q  <= {ADDR_W{1'b0}};
      m_wdata_q <= {DATA_W{1'b0}};
      m_wstrb_q <= {(DATA_W/8){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = in_ready_s;
  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_stream_mem_writer.sv
// Self-checking bench for stream_mem_writer: directed bursts for the
// called-out corner cases plus randomized bursts checked against a
// list-based model of the expected write sequence.
module tb_stream_mem_writer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 10;
  localparam int BUDGET = 1000;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  stream_mem_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one burst starting at posedge+1 and returns at posedge+1.
  // rmode < 0 means m_ready alternates 0,1 starting with 0.
  task automatic run_burst(input logic [31:0] base, input int n, input int vpct,
                           input int rmode, input bit restart, input bit ideal);
    logic [31:0] send_q[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_addr;
    logic [31:0] stall_addr;
    logic [31:0] stall_data;
    bit          stall_prev;
    bit          done_seen;
    int          cyc;
    int          done_cyc;
    int          busy_cnt;
    int          last_ack;
    int          extra_acc;
    for (int i = 0; i < n; i++) send_q.push_back($urandom);
    exp_data = send_q;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    stall_prev = 1'b0;
    done_seen  = 1'b0;
    cyc        = 0;
    done_cyc   = -1;
    busy_cnt   = 0;
    last_ack   = -1;
    extra_acc  = 0;

    start     = 1'b1;
    base_addr = base;
    len       = LEN_W'(n);
    in_valid  = (n == 0) ? 1'b1 : ($urandom_range(99) < vpct);
    in_data   = (send_q.size() > 0) ? send_q[0] : $urandom;
    m_ready   = (rmode < 0) ? 1'b0 : ($urandom_range(99) < rmode);

    while (!done_seen && cyc < BUDGET) begin
      @(negedge clk);
      if (cyc == 0) begin
        check_eq("idle_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("idle_busy", {63'd0, busy}, 64'd0);
      end
      if (stall_prev) begin
        check_eq("stall_valid", {63'd0, m_valid}, 64'd1);
        check_eq("stall_addr", {32'd0, m_addr}, {32'd0, stall_addr});
        check_eq("stall_data", {32'd0, m_wdata}, {32'd0, stall_data});
      end
      if (m_valid && !m_ready) begin
        check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
        stall_prev = 1'b1;
        stall_addr = m_addr;
        stall_data = m_wdata;
      end else begin
        stall_prev = 1'b0;
      end
      if (m_valid && m_ready) begin
        check_eq("wstrb", {60'd0, m_wstrb}, 64'hF);
        wr_addr_q.push_back(m_addr);
        wr_data_q.push_back(m_wdata);
        wr_cyc_q.push_back(cyc);
        last_ack = cyc;
      end
      if (in_valid && in_ready) begin
        if (send_q.size() > 0) void'(send_q.pop_front());
        else extra_acc++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      start     = restart && (cyc == 3);
      base_addr = base + 32'h0000_1230;
      len       = LEN_W'(n + 3);
      if (n == 0) in_valid = 1'b1;
      else in_valid = (send_q.size() > 0) && ($urandom_range(99) < vpct);
      in_data   = (send_q.size() > 0) ? send_q[0] : $urandom;
      m_ready   = (rmode < 0) ? cyc[0] : ($urandom_range(99) < rmode);
    end

    check_eq("done_seen", {63'd0, done_seen}, 64'd1);
    check_eq("extra_accepts", 64'(extra_acc), 64'd0);
    check_eq("write_count", 64'(wr_addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      exp_addr = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      check_eq("wr_addr", {32'd0, wr_addr_q[i]}, {32'd0, exp_addr});
      check_eq("wr_data", {32'd0, wr_data_q[i]}, {32'd0, exp_data[i]});
      if (ideal) check_eq("wr_cycle", 64'(wr_cyc_q[i]), 64'(2 + i));
    end
    if (n > 0 && done_seen) check_eq("done_after_ack", 64'(done_cyc), 64'(last_ack + 2));
    if (ideal) begin
      check_eq("done_cycle", 64'(done_cyc), (n == 0) ? 64'd2 : 64'(n + 3));
      check_eq("busy_cycles", 64'(busy_cnt), (n == 0) ? 64'd1 : 64'(n + 2));
    end

    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("done_pulse_end", {63'd0, done}, 64'd0);
    check_eq("busy_end", {63'd0, busy}, 64'd0);
    check_eq("valid_end", {63'd0, m_valid}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 32'd0;
    len       = 10'd0;
    in_data   = 32'd0;
    in_valid  = 1'b0;
    m_ready   = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_valid", {63'd0, m_valid}, 64'd0);
    check_eq("rst_addr", {32'd0, m_addr}, 64'd0);
    check_eq("rst_wdata", {32'd0, m_wdata}, 64'd0);
    check_eq("rst_wstrb", {60'd0, m_wstrb}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Full-throughput burst of four words
    run_burst(32'h0000_1000, 4, 100, 100, 1'b0, 1'b1);
    // Back-pressure alternating 0,1
    run_burst(32'h0000_2000, 3, 100, -1, 1'b0, 1'b0);
    // Zero-length request
    run_burst(32'h0000_3000, 0, 100, 100, 1'b0, 1'b1);
    // Address wrap at the top of the space
    run_burst(32'hFFFF_FFFC, 2, 100, 100, 1'b0, 1'b1);
    // Second start mid-burst must be ignored
    run_burst(32'h0000_4000, 6, 100, 100, 1'b1, 1'b1);

    // Reset during the second write of a five-word burst
    start     = 1'b1;
    base_addr = 32'h0000_5000;
    len       = 10'd5;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0001;
    m_ready   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_valid_pre", {63'd0, m_valid}, 64'd1);
    check_eq("mid_rst_addr_pre", {32'd0, m_addr}, 64'h5004);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", {63'd0, m_valid}, 64'd0);
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_addr", {32'd0, m_addr}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_done", {63'd0, done}, 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_no_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    run_burst(32'h0000_6000, 5, 100, 100, 1'b0, 1'b1);

    // Randomized bursts
    for (int k = 0; k < 20; k++) begin
      run_burst($urandom, $urandom_range(0, 12), $urandom_range(30, 100),
                $urandom_range(30, 100), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
